change_dispenser: RTL and testbench

Downstream of the vending controller. Accepts the change amount presented with the dispense strobe and pays it out one coin at a time to a coin hopper over a req/ack handshake. Uses greedy denomination selection (20, 10, 5) against per-denomination inventory counters, which a refill port can top up. Reports completion with a done pulse, or a sticky fault on short-change or hopper timeout.

---
 rtl/vend_pkg.sv | 31 +++
 rtl/coin_inventory.sv | 54 +++++
 rtl/change_dispenser.sv | 149 ++++++++++++++
 tb/tb_change_dispenser.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared vending definitions: coin encoding (common to the vending controller),
// coin face values and the change-dispenser state enum.
package vend_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_20   = 2'b11;

  localparam int COIN_VAL_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_EJECT  = 3'd2,
    ST_GAP    = 3'd3,
    ST_DONE   = 3'd4,
    ST_FAULT  = 3'd5
  } cd_state_e;

  // Callers cast the result to their own amount width.
  function automatic logic [COIN_VAL_W-1:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_5:  return 8'd5;
      COIN_10: return 8'd10;
      COIN_20: return 8'd20;
      default: return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/coin_inventory.sv
// Per-denomination coin counters: refill increments, dispense decrements,
// both saturating; a simultaneous refill and dispense of one denomination cancel.
module coin_inventory
  import vend_pkg::*;
#(
  parameter int INV_W   = 8,
  parameter int INIT_5  = 10,
  parameter int INIT_10 = 10,
  parameter int INIT_20 = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_refill,
  input  logic [1:0] i_refill_den,
  input  logic       i_dec,
  input  logic [1:0] i_dec_den,
  output logic       o_avail_5,
  output logic       o_avail_10,
  output logic       o_avail_20
);

  localparam logic [INV_W-1:0] INV_MAX = '1;

  logic [INV_W-1:0] r_inv_5;
  logic [INV_W-1:0] r_inv_10;
  logic [INV_W-1:0] r_inv_20;

  function automatic logic [INV_W-1:0] next_cnt(input logic [INV_W-1:0] cur,
                                                input logic inc, input logic dec);
    if (inc && !dec && (cur != INV_MAX)) return cur + 1'b1;
    if (dec && !inc && (cur != '0))      return cur - 1'b1;
    return cur;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inv_5  <= INV_W'(INIT_5);
      r_inv_10 <= INV_W'(INIT_10);
      r_inv_20 <= INV_W'(INIT_20);
    end else begin
      r_inv_5  <= next_cnt(r_inv_5,  i_refill && (i_refill_den == COIN_5),
                                     i_dec && (i_dec_den == COIN_5));
      r_inv_10 <= next_cnt(r_inv_10, i_refill && (i_refill_den == COIN_10),
                                     i_dec && (i_dec_den == COIN_10));
      r_inv_20 <= next_cnt(r_inv_20, i_refill && (i_refill_den == COIN_20),
                                     i_dec && (i_dec_den == COIN_20));
    end
  end

  assign o_avail_5  = (r_inv_5  != '0);
  assign o_avail_10 = (r_inv_10 != '0);
  assign o_avail_20 = (r_inv_20 != '0);

endmodule

// File: rtl/change_dispenser.sv
// Pays out a change amount one coin at a time (greedy 20/10/5) over an
// eject_req/eject_ack handshake; raises a sticky fault on short-change or hopper timeout.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W       = 6,
  parameter int INV_W       = 8,
  parameter int INIT_INV_5  = 10,
  parameter int INIT_INV_10 = 10,
  parameter int INIT_INV_20 = 10,
  parameter int TIMEOUT     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             refill,
  input  logic [1:0]       refill_den,
  output logic             eject_req,
  output logic [1:0]       eject_den,
  input  logic             eject_ack,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [AMT_W-1:0] remaining,
  output cd_state_e        dbg_state
);

  // Handshake: eject_req rises with eject_den already valid and both hold until
  // the first cycle eject_ack is sampled high; that cycle transfers one coin.
  // eject_ack outside an active request is ignored.

  localparam int               WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [AMT_W-1:0] VAL_5     = AMT_W'(coin_value(COIN_5));
  localparam logic [AMT_W-1:0] VAL_10    = AMT_W'(coin_value(COIN_10));
  localparam logic [AMT_W-1:0] VAL_20    = AMT_W'(coin_value(COIN_20));

  cd_state_e         r_state;
  logic [AMT_W-1:0]  r_remaining;
  logic [1:0]        r_eject_den;
  logic [WAIT_W-1:0] r_wait;
  logic              r_eject_req;
  logic              r_busy;
  logic              r_done;
  logic              r_fault;

  logic              w_avail_5;
  logic              w_avail_10;
  logic              w_avail_20;
  logic [1:0]        w_pick;
  logic              w_dec;
  logic [AMT_W-1:0]  w_coin_val;

  assign w_dec      = r_eject_req && eject_ack;
  assign w_coin_val = AMT_W'(coin_value(r_eject_den));

  coin_inventory #(
    .INV_W   (INV_W),
    .INIT_5  (INIT_INV_5),
    .INIT_10 (INIT_INV_10),
    .INIT_20 (INIT_INV_20)
  ) u_inv (
    .clk          (clk),
    .rst          (rst),
    .i_refill     (refill),
    .i_refill_den (refill_den),
    .i_dec        (w_dec),
    .i_dec_den    (r_eject_den),
    .o_avail_5    (w_avail_5),
    .o_avail_10   (w_avail_10),
    .o_avail_20   (w_avail_20)
  );

  // Largest coin that fits in the remaining amount and is in stock.
  always_comb begin
    w_pick = COIN_NONE;
    if ((r_remaining >= VAL_20) && w_avail_20)      w_pick = COIN_20;
    else if ((r_remaining >= VAL_10) && w_avail_10) w_pick = COIN_10;
    else if ((r_remaining >= VAL_5) && w_avail_5)   w_pick = COIN_5;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_eject_den <= COIN_NONE;
      r_wait      <= '0;
      r_eject_req <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_remaining <= amount;
            r_busy      <= 1'b1;
            r_state     <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (r_remaining == '0) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else if (w_pick != COIN_NONE) begin
            r_eject_den <= w_pick;
            r_wait      <= '0;
            r_eject_req <= 1'b1;
            r_state     <= ST_EJECT;
          end else begin
            r_fault <= 1'b1;
            r_state <= ST_FAULT;
          end
        end
        ST_EJECT: begin
          if (eject_ack) begin
            r_remaining <= r_remaining - w_coin_val;
            r_eject_req <= 1'b0;
            r_state     <= ST_GAP;
          end else if (r_wait == WAIT_LAST) begin
            r_eject_req <= 1'b0;
            r_fault     <= 1'b1;
            r_state     <= ST_FAULT;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        ST_GAP:   r_state <= ST_SELECT;
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        ST_FAULT: r_state <= ST_FAULT;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign eject_req = r_eject_req;
  assign eject_den = r_eject_den;
  assign busy      = r_busy;
  assign done      = r_done;
  assign fault     = r_fault;
  assign remaining = r_remaining;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: three instances with different starting
// inventories share stimulus; sel picks which one is driven and observed.
module tb_change_dispenser;
  import vend_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start;
  logic [5:0] amount;
  logic       refill;
  logic [1:0] refill_den;
  logic       eject_ack;
  int         sel;

  logic       req_a  [3];
  logic [1:0] den_a  [3];
  logic       busy_a [3];
  logic       done_a [3];
  logic       fault_a[3];
  logic [5:0] rem_a  [3];
  cd_state_e  st_a   [3];

  change_dispenser u_d0 (
    .clk(clk), .rst(rst), .start(start && (sel == 0)), .amount(amount),
    .refill(refill && (sel == 0)), .refill_den(refill_den),
    .eject_req(req_a[0]), .eject_den(den_a[0]), .eject_ack(eject_ack && (sel == 0)),
    .busy(busy_a[0]), .done(done_a[0]), .fault(fault_a[0]), .remaining(rem_a[0]),
    .dbg_state(st_a[0]));

  change_dispenser #(.INIT_INV_20(0)) u_d1 (
    .clk(clk), .rst(rst), .start(start && (sel == 1)), .amount(amount),
    .refill(refill && (sel == 1)), .refill_den(refill_den),
    .eject_req(req_a[1]), .eject_den(den_a[1]), .eject_ack(eject_ack && (sel == 1)),
    .busy(busy_a[1]), .done(done_a[1]), .fault(fault_a[1]), .remaining(rem_a[1]),
    .dbg_state(st_a[1]));

  change_dispenser #(.INIT_INV_5(1), .INIT_INV_10(0)) u_d2 (
    .clk(clk), .rst(rst), .start(start && (sel == 2)), .amount(amount),
    .refill(refill && (sel == 2)), .refill_den(refill_den),
    .eject_req(req_a[2]), .eject_den(den_a[2]), .eject_ack(eject_ack && (sel == 2)),
    .busy(busy_a[2]), .done(done_a[2]), .fault(fault_a[2]), .remaining(rem_a[2]),
    .dbg_state(st_a[2]));

  logic       req, busy, done, fault;
  logic [1:0] den;
  logic [5:0] rem;
  cd_state_e  st;
  logic [7:0] inv5, inv10, inv20;

  always_comb begin
    req = req_a[sel]; den = den_a[sel]; busy = busy_a[sel]; done = done_a[sel];
    fault = fault_a[sel]; rem = rem_a[sel]; st = st_a[sel];
    case (sel)
      1:       begin inv5 = u_d1.u_inv.r_inv_5; inv10 = u_d1.u_inv.r_inv_10; inv20 = u_d1.u_inv.r_inv_20; end
      2:       begin inv5 = u_d2.u_inv.r_inv_5; inv10 = u_d2.u_inv.r_inv_10; inv20 = u_d2.u_inv.r_inv_20; end
      default: begin inv5 = u_d0.u_inv.r_inv_5; inv10 = u_d0.u_inv.r_inv_10; inv20 = u_d0.u_inv.r_inv_20; end
    endcase
  end

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- driver / hopper ----------------
  // Starts a payout on the current negedge, plays the hopper (acking every request
  // on its first cycle when ack_en), and stops at done or fault. n counts negedges
  // after the start cycle. A stray start with amount 63 is issued at n==3.
  task automatic run(input logic [5:0] amt, input bit ack_en, input bit refill_on_ack,
                     output int first_req_n, output int end_n, output int req_cycles);
    int   n;
    logic prev_req;
    bit   fin;
    n = 0; prev_req = 1'b0; fin = 1'b0;
    first_req_n = -1; end_n = -1; req_cycles = 0;
    amount = amt; start = 1'b1;
    while (!fin && (n < 100)) begin
      @(negedge clk);
      n++;
      start = (n == 3);
      if (n == 3) amount = 6'd63;
      eject_ack = 1'b0; refill = 1'b0; refill_den = COIN_NONE;
      if (req) begin
        req_cycles++;
        if (first_req_n < 0) first_req_n = n;
        if (!prev_req) begin
          if (exp_q.size() == 0) check("extra_coin", 1, 0);
          else check("coin_den", den, exp_q.pop_front());
        end
        if (ack_en) begin
          eject_ack = 1'b1;
          if (refill_on_ack) begin refill = 1'b1; refill_den = den; end
        end
      end
      prev_req = req;
      if (done || fault) begin fin = 1'b1; end_n = n; end
    end
    start = 1'b0; eject_ack = 1'b0; refill = 1'b0; refill_den = COIN_NONE;
    check("end_in_budget", fin, 1);
    check("coins_left", exp_q.size(), 0);
  endtask

  // ---------------- directed tests ----------------
  int f, e, rc;

  initial begin
    rst = 1'b1; start = 1'b0; amount = '0; refill = 1'b0;
    refill_den = COIN_NONE; eject_ack = 1'b0; sel = 0;
    repeat (2) @(negedge clk);
    check("rst_req", req, 0);    check("rst_den", den, 0);
    check("rst_busy", busy, 0);  check("rst_done", done, 0);
    check("rst_fault", fault, 0); check("rst_rem", rem, 0);
    check("rst_state", st, ST_IDLE);
    check("rst_inv5", inv5, 10); check("rst_inv10", inv10, 10); check("rst_inv20", inv20, 10);
    rst = 1'b0;
    @(negedge clk);

    // 15 -> 10, 5
    exp_q = '{COIN_10, COIN_5};
    run(6'd15, 1, 0, f, e, rc);
    check("t1_first_req", f, 2); check("t1_done_n", e, 8); check("t1_done", done, 1);
    check("t1_rem", rem, 0); check("t1_inv10", inv10, 9); check("t1_inv5", inv5, 9);
    @(negedge clk);
    check("t1_done_pulse", done, 0); check("t1_idle", busy, 0);

    // 35 -> 20, 10, 5 with a start issued while busy
    exp_q = '{COIN_20, COIN_10, COIN_5};
    run(6'd35, 1, 0, f, e, rc);
    check("t2_first_req", f, 2); check("t2_done_n", e, 11); check("t2_rem", rem, 0);
    check("t2_inv20", inv20, 9); check("t2_inv10", inv10, 8); check("t2_inv5", inv5, 8);
    @(negedge clk);
    check("t2_idle", busy, 0); check("t2_rem_kept", rem, 0);

    // refill of a 10 on the same cycle as the ack of a 10
    exp_q = '{COIN_10};
    run(6'd10, 1, 1, f, e, rc);
    check("t6_done_n", e, 5); check("t6_inv10", inv10, 8);
    @(negedge clk);

    // amount 0
    run(6'd0, 1, 0, f, e, rc);
    check("zero_done_n", e, 2); check("zero_no_req", rc, 0); check("zero_done", done, 1);
    @(negedge clk);

    // hopper never acks
    exp_q = '{COIN_5};
    run(6'd5, 0, 0, f, e, rc);
    check("to_req_cycles", rc, 16); check("to_fault_n", e, 18); check("to_fault", fault, 1);
    check("to_req_low", req, 0); check("to_rem", rem, 5); check("to_inv5", inv5, 8);
    repeat (2) @(negedge clk);
    check("to_sticky", fault, 1); check("to_state", st, ST_FAULT); check("to_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("to_rst_fault", fault, 0); check("to_rst_inv5", inv5, 10); check("to_rst_inv10", inv10, 10);
    rst = 1'b0;
    @(negedge clk);

    // rst during EJECT
    amount = 6'd5; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check("re_req_up", req, 1); check("re_den", den, COIN_5);
    rst = 1'b1;
    @(negedge clk);
    check("re_req", req, 0); check("re_den0", den, 0); check("re_busy", busy, 0);
    check("re_rem", rem, 0); check("re_state", st, ST_IDLE);
    rst = 1'b0;
    @(negedge clk);

    // refill saturation, then a refill with code 00
    refill = 1'b1; refill_den = COIN_20;
    repeat (250) @(negedge clk);
    refill_den = COIN_NONE;
    @(negedge clk);
    refill = 1'b0;
    check("sat_inv20", inv20, 255); check("none_inv5", inv5, 10); check("none_inv10", inv10, 10);

    // no 20s in stock: 20 -> 10, 10
    sel = 1;
    exp_q = '{COIN_10, COIN_10};
    run(6'd20, 1, 0, f, e, rc);
    check("t3_done_n", e, 8); check("t3_inv10", inv10, 8); check("t3_inv20", inv20, 0);
    @(negedge clk);

    // short change: one 5, no 10s, amount 10
    sel = 2;
    exp_q = '{COIN_5};
    run(6'd10, 1, 0, f, e, rc);
    check("t4_fault_n", e, 5); check("t4_fault", fault, 1); check("t4_rem", rem, 5);
    check("t4_req", req, 0); check("t4_inv5", inv5, 0);
    refill = 1'b1; refill_den = COIN_5;
    @(negedge clk);
    refill = 1'b0; refill_den = COIN_NONE;
    check("t4_refill_inv5", inv5, 1); check("t4_refill_fault", fault, 1);
    repeat (3) @(negedge clk);
    check("t4_req_low", req, 0); check("t4_still_fault", fault, 1);
    rst = 1'b1;
    @(negedge clk);
    check("t4_rst_fault", fault, 0); check("t4_rst_rem", rem, 0);
    check("t4_rst_inv5", inv5, 1); check("t4_rst_inv10", inv10, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
